// File: rtl/ldpc_iter_scheduler.sv
// Frame-level sequencer for the layered QC-LDPC decoder.
// Loads one frame of LLR beats into the LLR memory.
// Drives the layer processor through layers and iterations, stopping early
// on a passing syndrome, then streams the decoded frame back out.
module ldpc_iter_scheduler #(
  parameter int BEATS      = 16,
  parameter int NUM_LAYERS = 4,
  parameter int MAX_ITER   = 8,
  localparam int AW        = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [15:0]   i_z,
  output logic [31:0]   lane_mask,
  output logic          load_we,
  output logic [AW-1:0] load_addr,
  output logic          layer_start,
  output logic [LW-1:0] layer_idx,
  input  logic          layer_done,
  input  logic          syndrome_ok,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          o_valid,
  output logic          o_last,
  output logic          busy,
  output logic [3:0]    o_iters,
  output logic          o_early
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] UNLOAD = 3'd5;

  localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [3:0]    LAST_ITER  = 4'(MAX_ITER - 1);

  logic [2:0]    state_reg;
  logic [AW-1:0] beat_cnt_reg;
  logic [AW-1:0] rd_cnt_reg;
  logic [3:0]    iter_reg;
  logic          o_valid_reg;
  logic          o_last_reg;

  // Lifting size decode: only the low six bits matter; 0 or anything above
  // 32 means every lane is active.
  logic [5:0]  z_raw;
  logic        z_full;
  logic [31:0] mask_next;
  logic        unused_z_hi;

  assign z_raw       = i_z[5:0];
  assign z_full      = (z_raw == 6'd0) || (z_raw > 6'd32);
  assign unused_z_hi = ^i_z[15:6];

  // Lane gi is enabled when it falls below the effective lifting size.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_lane
      assign mask_next[gi] = z_full || (z_raw > 6'(gi));
    end
  endgenerate

  // Input side accepts beats only while collecting a frame.
  assign i_ready     = (state_reg == IDLE) || (state_reg == LOAD);
  assign load_we     = i_valid && i_ready;
  assign load_addr   = beat_cnt_reg;
  assign layer_start = (state_reg == ISSUE);
  assign rd_en       = (state_reg == UNLOAD);
  assign rd_addr     = rd_cnt_reg;
  assign busy        = (state_reg != IDLE);
  assign o_valid     = o_valid_reg;
  assign o_last      = o_last_reg;

  // Frame sequencer: load, layer/iteration loop, syndrome check, unload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      rd_cnt_reg   <= '0;
      iter_reg     <= '0;
      layer_idx    <= '0;
      lane_mask    <= '1;
      o_iters      <= '0;
      o_early      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_we) begin
            // First beat of a frame fixes the lane mask for the whole frame.
            lane_mask    <= mask_next;
            beat_cnt_reg <= AW'(1);
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          if (load_we) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              layer_idx    <= '0;
              iter_reg     <= '0;
              state_reg    <= ISSUE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + AW'(1);
            end
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (layer_done) begin
            if (layer_idx == LAST_LAYER) begin
              state_reg <= CHECK;
            end else begin
              layer_idx <= layer_idx + LW'(1);
              state_reg <= ISSUE;
            end
          end
        end
        CHECK: begin
          if (syndrome_ok || (iter_reg == LAST_ITER)) begin
            o_early    <= syndrome_ok;
            o_iters    <= iter_reg + 4'd1;
            layer_idx  <= '0;
            rd_cnt_reg <= '0;
            state_reg  <= UNLOAD;
          end else begin
            iter_reg  <= iter_reg + 4'd1;
            layer_idx <= '0;
            state_reg <= ISSUE;
          end
        end
        UNLOAD: begin
          if (rd_cnt_reg == LAST_BEAT) begin
            rd_cnt_reg <= '0;
            state_reg  <= IDLE;
          end else begin
            rd_cnt_reg <= rd_cnt_reg + AW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output strobes trail the read by one cycle to line up with memory data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid_reg <= 1'b0;
      o_last_reg  <= 1'b0;
    end else begin
      o_valid_reg <= rd_en;
      o_last_reg  <= rd_en && (rd_cnt_reg == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_ldpc_iter_scheduler.sv
// Self-checking bench for ldpc_iter_scheduler: frame load, layer/iteration
// sequencing, lifting-size decode, unload timing and mid-frame reset.
module tb_ldpc_iter_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_z;
  logic [31:0] lane_mask;
  logic        load_we;
  logic [3:0]  load_addr;
  logic        layer_start;
  logic [1:0]  layer_idx;
  logic        layer_done;
  logic        syndrome_ok;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        o_valid;
  logic        o_last;
  logic        busy;
  logic [3:0]  o_iters;
  logic        o_early;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard: expected values pushed with stimulus, observed values
  // recorded while the DUT runs; tests pop and compare.
  int exp_wr[$], obs_wr[$];
  int exp_rd[$], obs_rd[$];
  int exp_lidx[$], obs_lidx[$];
  int ls_count, ov_count, olast_idx, first_beat_cyc, last_ov_cyc;
  bit timed_out;

  ldpc_iter_scheduler #(.BEATS(16), .NUM_LAYERS(4), .MAX_ITER(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_z(i_z),
    .lane_mask(lane_mask), .load_we(load_we), .load_addr(load_addr),
    .layer_start(layer_start), .layer_idx(layer_idx), .layer_done(layer_done),
    .syndrome_ok(syndrome_ok), .rd_en(rd_en), .rd_addr(rd_addr),
    .o_valid(o_valid), .o_last(o_last), .busy(busy), .o_iters(o_iters),
    .o_early(o_early)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected write/read address streams and layer index sequence of a frame.
  task automatic push_exp_frame(input int layers);
    for (int i = 0; i < 16; i++) begin
      exp_wr.push_back(i);
      exp_rd.push_back(i);
    end
    for (int i = 0; i < layers; i++) exp_lidx.push_back(i % 4);
  endtask

  // Drives one frame and records what the DUT does until o_last.
  task automatic run_frame(input int z0, input bit gaps, input bit offer,
                           input int done_delay, input int pass_iter, input bit spurious);
    int beats, rd_seen, done_at, budget;
    bit fin;
    obs_wr.delete(); obs_rd.delete(); obs_lidx.delete();
    ls_count = 0; ov_count = 0; olast_idx = -1; first_beat_cyc = -1; last_ov_cyc = -1;
    timed_out = 0; beats = 0; rd_seen = 0; done_at = -1; budget = 0; fin = 0;
    if (spurious) begin
      repeat (2) begin
        @(negedge clk);
        i_valid = 1'b0; layer_done = 1'b1;
      end
    end
    while (!fin && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (beats < 16) i_valid = gaps ? (budget % 2 == 1) : 1'b1;
      else i_valid = offer && (rd_seen == 0);
      i_z = (beats == 0) ? 16'(z0) : 16'($urandom);
      layer_done = (cyc == done_at) || (spurious && done_at >= 0 && cyc == done_at + 1);
      syndrome_ok = (ls_count >= 4 * pass_iter);
      #1;
      if (load_we) begin
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        obs_wr.push_back(int'(load_addr));
        beats++;
      end
      if (layer_start) begin
        ls_count++;
        obs_lidx.push_back(int'(layer_idx));
        done_at = cyc + done_delay;
      end
      if (rd_en) begin
        rd_seen++;
        obs_rd.push_back(int'(rd_addr));
      end
      if (o_valid) begin
        ov_count++;
        last_ov_cyc = cyc;
        if (o_last) begin
          olast_idx = ov_count;
          fin = 1;
        end
      end
    end
    timed_out = !fin;
    i_valid = 1'b0; layer_done = 1'b0; syndrome_ok = 1'b0; i_z = '0;
  endtask

  task automatic test_reset;
    int e, o;
    rst = 1'b0; i_valid = 1'b0; layer_done = 1'b0; syndrome_ok = 1'b0; i_z = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b, required 1", i_ready); end
    n_checks++; if (lane_mask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_lane_mask: got %h, required ffffffff", lane_mask); end
    n_checks++; if (load_we !== 1'b0) begin n_fail++; $display("FAIL reset_load_we: got %b, required 0", load_we); end
    n_checks++; if (load_addr !== 4'd0) begin n_fail++; $display("FAIL reset_load_addr: got %0d, required 0", load_addr); end
    n_checks++; if (layer_start !== 1'b0) begin n_fail++; $display("FAIL reset_layer_start: got %b, required 0", layer_start); end
    n_checks++; if (layer_idx !== 2'd0) begin n_fail++; $display("FAIL reset_layer_idx: got %0d, required 0", layer_idx); end
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, required 0", rd_en); end
    n_checks++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d, required 0", rd_addr); end
    n_checks++; if (o_valid !== 1'b0 || o_last !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid_last: got %b%b, required 00", o_valid, o_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (o_iters !== 4'd0 || o_early !== 1'b0) begin n_fail++; $display("FAIL reset_iters_early: got %0d/%b, required 0/0", o_iters, o_early); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release: busy/i_ready %b/%b, required 0/1", busy, i_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_basic;
    int e, o;
    push_exp_frame(4);
    run_frame(16, 0, 0, 1, 1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: frame did not finish, required o_last"); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL basic_wr: missing, required addr %0d", e); end
      else begin o = obs_wr.pop_front(); if (o !== e) begin n_fail++; $display("FAIL basic_wr: addr %0d, required %0d", o, e); end end
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); n_checks++;
      if (obs_rd.size() == 0) begin n_fail++; $display("FAIL basic_rd: missing, required addr %0d", e); end
      else begin o = obs_rd.pop_front(); if (o !== e) begin n_fail++; $display("FAIL basic_rd: addr %0d, required %0d", o, e); end end
    end
    while (exp_lidx.size() > 0) begin
      e = exp_lidx.pop_front(); n_checks++;
      if (obs_lidx.size() == 0) begin n_fail++; $display("FAIL basic_lidx: missing, required %0d", e); end
      else begin o = obs_lidx.pop_front(); if (o !== e) begin n_fail++; $display("FAIL basic_lidx: got %0d, required %0d", o, e); end end
    end
    n_checks++; if (obs_wr.size() + obs_rd.size() + obs_lidx.size() != 0) begin n_fail++; $display("FAIL basic_extra: %0d surplus events, required 0", obs_wr.size() + obs_rd.size() + obs_lidx.size()); end
    n_checks++; if (lane_mask !== 32'h0000_FFFF) begin n_fail++; $display("FAIL basic_lane_mask: got %h, required 0000ffff", lane_mask); end
    n_checks++; if (ls_count != 4) begin n_fail++; $display("FAIL basic_layer_starts: got %0d, required 4", ls_count); end
    n_checks++; if (o_iters !== 4'd1 || o_early !== 1'b1) begin n_fail++; $display("FAIL basic_iters_early: got %0d/%b, required 1/1", o_iters, o_early); end
    n_checks++; if (ov_count != 16 || olast_idx != 16) begin n_fail++; $display("FAIL basic_o_valid: count %0d last at %0d, required 16/16", ov_count, olast_idx); end
    n_checks++; if (last_ov_cyc - first_beat_cyc != 41) begin n_fail++; $display("FAIL basic_latency: span %0d cycles, required 42", last_ov_cyc - first_beat_cyc + 1); end
    $display("test_basic: layer_starts=%0d o_iters=%0d span=%0d", ls_count, o_iters, last_ov_cyc - first_beat_cyc + 1);
  endtask

  task automatic test_max_iter;
    int e, o;
    n_checks++; if (o_iters !== 4'd1 || o_early !== 1'b1) begin n_fail++; $display("FAIL hold_iters_early: got %0d/%b, required 1/1", o_iters, o_early); end
    push_exp_frame(32);
    exp_wr.delete(); exp_rd.delete();
    run_frame(8, 0, 0, 1, 99, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL maxit_timeout: frame did not finish, required o_last"); end
    while (exp_lidx.size() > 0) begin
      e = exp_lidx.pop_front(); n_checks++;
      if (obs_lidx.size() == 0) begin n_fail++; $display("FAIL maxit_lidx: missing, required %0d", e); end
      else begin o = obs_lidx.pop_front(); if (o !== e) begin n_fail++; $display("FAIL maxit_lidx: got %0d, required %0d", o, e); end end
    end
    n_checks++; if (ls_count != 32) begin n_fail++; $display("FAIL maxit_layer_starts: got %0d, required 32", ls_count); end
    n_checks++; if (o_iters !== 4'd8 || o_early !== 1'b0) begin n_fail++; $display("FAIL maxit_iters_early: got %0d/%b, required 8/0", o_iters, o_early); end
    n_checks++; if (lane_mask !== 32'h0000_00FF) begin n_fail++; $display("FAIL maxit_lane_mask: got %h, required 000000ff", lane_mask); end
    $display("test_max_iter: layer_starts=%0d o_iters=%0d o_early=%b", ls_count, o_iters, o_early);
  endtask

  task automatic test_z_clamp;
    run_frame(0, 0, 0, 1, 2, 0);
    n_checks++; if (lane_mask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL z0_lane_mask: got %h, required ffffffff", lane_mask); end
    n_checks++; if (o_iters !== 4'd2 || o_early !== 1'b1) begin n_fail++; $display("FAIL z0_iters_early: got %0d/%b, required 2/1", o_iters, o_early); end
    $display("test_z_clamp: z=0 lane_mask=%h o_iters=%0d", lane_mask, o_iters);
    run_frame(45, 0, 0, 1, 1, 0);
    n_checks++; if (lane_mask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL z45_lane_mask: got %h, required ffffffff", lane_mask); end
    $display("test_z_clamp: z=45 lane_mask=%h", lane_mask);
    run_frame(16'h0FC5, 0, 0, 1, 1, 0);
    n_checks++; if (lane_mask !== 32'h0000_001F) begin n_fail++; $display("FAIL z5_lane_mask: got %h, required 0000001f", lane_mask); end
    $display("test_z_clamp: z=0x0fc5 lane_mask=%h", lane_mask);
  endtask

  task automatic test_gaps_and_wait_beats;
    int e, o;
    push_exp_frame(4);
    exp_rd.delete(); exp_lidx.delete();
    run_frame(32, 1, 1, 3, 1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL gaps_timeout: frame did not finish, required o_last"); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL gaps_wr: missing, required addr %0d", e); end
      else begin o = obs_wr.pop_front(); if (o !== e) begin n_fail++; $display("FAIL gaps_wr: addr %0d, required %0d", o, e); end end
    end
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL gaps_extra_writes: %0d, required 0", obs_wr.size()); end
    n_checks++; if (lane_mask !== 32'hFFFF_FFFF || ls_count != 4) begin n_fail++; $display("FAIL gaps_mask_starts: %h/%0d, required ffffffff/4", lane_mask, ls_count); end
    $display("test_gaps_and_wait_beats: writes ok, layer_starts=%0d", ls_count);
  endtask

  task automatic test_reset_mid_frame;
    int e, o;
    for (int b = 0; b < 9; b++) begin
      @(negedge clk);
      i_valid = 1'b1; i_z = 16'd12;
    end
    @(negedge clk);
    i_valid = 1'b1;
    #1;
    n_checks++; if (load_we !== 1'b1 || load_addr !== 4'd9) begin n_fail++; $display("FAIL midrst_beat9: we/addr %b/%0d, required 1/9", load_we, load_addr); end
    rst = 1'b0; i_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || i_ready !== 1'b1 || load_addr !== 4'd0) begin n_fail++; $display("FAIL midrst_clear: busy/ready/addr %b/%b/%0d, required 0/1/0", busy, i_ready, load_addr); end
    n_checks++; if (lane_mask !== 32'hFFFF_FFFF || o_iters !== 4'd0) begin n_fail++; $display("FAIL midrst_regs: mask/iters %h/%0d, required ffffffff/0", lane_mask, o_iters); end
    @(negedge clk);
    rst = 1'b1;
    push_exp_frame(4);
    exp_lidx.delete();
    run_frame(4, 0, 0, 1, 1, 1);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL midrst_timeout: frame did not finish, required o_last"); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front(); n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL midrst_wr: missing, required addr %0d", e); end
      else begin o = obs_wr.pop_front(); if (o !== e) begin n_fail++; $display("FAIL midrst_wr: addr %0d, required %0d", o, e); end end
    end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front(); n_checks++;
      if (obs_rd.size() == 0) begin n_fail++; $display("FAIL midrst_rd: missing, required addr %0d", e); end
      else begin o = obs_rd.pop_front(); if (o !== e) begin n_fail++; $display("FAIL midrst_rd: addr %0d, required %0d", o, e); end end
    end
    n_checks++; if (ls_count != 4 || lane_mask !== 32'h0000_000F) begin n_fail++; $display("FAIL midrst_frame: starts/mask %0d/%h, required 4/0000000f", ls_count, lane_mask); end
    n_checks++; if (o_iters !== 4'd1 || o_early !== 1'b1) begin n_fail++; $display("FAIL midrst_iters_early: got %0d/%b, required 1/1", o_iters, o_early); end
    $display("test_reset_mid_frame: layer_starts=%0d lane_mask=%h", ls_count, lane_mask);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max_iter;
    test_z_clamp;
    test_gaps_and_wait_beats;
    test_reset_mid_frame;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
